// File: rtl/seq_decoder_pkg.sv
// seq_decoder_pkg
// Shared types and constants for the sequence decoder.
//   state_e     : controller states (IDLE, HOLD, SCAN)
//   DWELL_CNT_W : width of the scan dwell counter; covers DWELL values up to 255
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    localparam int DWELL_CNT_W = 8;

endpackage

// File: rtl/seq_decoder_onehot_dec.sv
// onehot_dec
// Purely combinational index-to-one-hot decoder.
// Ports:
//   idx_i    : ADDR_W-bit index of the bit to assert
//   en_i     : 1 asserts bit idx_i, 0 forces the output to all zero
//   onehot_o : 2**ADDR_W-bit one-hot (or all-zero) result
module onehot_dec #(
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0]      idx_i,
    input  logic                   en_i,
    output logic [2**ADDR_W-1:0]   onehot_o
);

    localparam int OUT_W = 2**ADDR_W;

    // A single shifted bit keeps the result one-hot by construction.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o = OUT_W'(1) << idx_i;
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// seq_decoder
// Registered address decoder with a direct command path and an optional
// walking one-hot scan mode.
// Build option: define SEQ_DECODER_SCAN_EN to include the SCAN state, the
// dwell counter and the scan_start/scan_stop controls. Without it the scan
// inputs are ignored, busy is 0 and cmd_ready is 1.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : direct command offered
//   cmd_ready  : command accepted this cycle when high together with cmd_valid
//   cmd_addr   : output index selected by the command
//   cmd_enable : 1 drives the selected output, 0 clears all outputs
//   scan_start : single-cycle pulse entering scan mode
//   scan_stop  : single-cycle pulse leaving scan mode
//   out        : registered one-hot or all-zero decode result
//   addr_out   : index of the asserted bit, 0 when out is zero
//   busy       : high while scanning
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DWELL  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic                  cmd_enable,
    input  logic                  scan_start,
    input  logic                  scan_stop,
    output logic [2**ADDR_W-1:0]  out,
    output logic [ADDR_W-1:0]     addr_out,
    output logic                  busy
);

    localparam int OUT_W = 2**ADDR_W;

    state_e              state_q;
    logic [OUT_W-1:0]    out_q;
    logic [ADDR_W-1:0]   addr_q;

    logic [ADDR_W-1:0]   dec_idx_d;
    logic                dec_en_d;
    logic [OUT_W-1:0]    dec_onehot;
    logic [ADDR_W-1:0]   addr_d;
    logic                cmd_accept;

    // The decoder sees the next index/enable, so out_q is loaded straight
    // from its one-hot result and can never hold more than one set bit.
    onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_onehot_dec (
        .idx_i    (dec_idx_d),
        .en_i     (dec_en_d),
        .onehot_o (dec_onehot)
    );

    // addr_out follows out: zero whenever nothing is asserted.
    assign addr_d   = dec_en_d ? dec_idx_d : '0;
    assign out      = out_q;
    assign addr_out = addr_q;

`ifdef SEQ_DECODER_SCAN_EN

    localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL - 1);

    logic [DWELL_CNT_W-1:0] cnt_q;
    logic                   dwell_done;

    // scan_start takes priority over a coincident command, so the handshake
    // is withheld in that cycle as well as throughout SCAN.
    assign cmd_ready  = (state_q != SCAN) && !scan_start;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign busy       = (state_q == SCAN);
    assign dwell_done = (cnt_q == DWELL_LAST);

    // Next decode selection. In SCAN the index advances on the last dwell
    // cycle; the ADDR_W-bit add wraps to 0 with no gap. scan_stop wins
    // over scan_start while scanning because scan_start is ignored there.
    always_comb begin
        dec_idx_d = addr_q;
        dec_en_d  = 1'b0;
        case (state_q)
            SCAN: begin
                if (!scan_stop) begin
                    dec_en_d = 1'b1;
                    if (dwell_done) begin
                        dec_idx_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                if (scan_start) begin
                    dec_idx_d = '0;
                    dec_en_d  = 1'b1;
                end else if (cmd_accept) begin
                    dec_idx_d = cmd_addr;
                    dec_en_d  = cmd_enable;
                end else begin
                    dec_en_d  = (state_q == HOLD);
                end
            end
        endcase
    end

    // Controller state, registered outputs and dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            out_q  <= dec_onehot;
            addr_q <= addr_d;
            case (state_q)
                SCAN: begin
                    if (scan_stop) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (dwell_done) begin
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + DWELL_CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q <= '0;
                    if (scan_start) begin
                        state_q <= SCAN;
                    end else if (cmd_accept) begin
                        state_q <= cmd_enable ? HOLD : IDLE;
                    end
                end
            endcase
        end
    end

`else

    localparam int unused_dwell = DWELL;

    logic unused_scan;

    assign unused_scan = scan_start ^ scan_stop;
    assign cmd_ready   = 1'b1;
    assign cmd_accept  = cmd_valid;
    assign busy        = 1'b0;

    // Without scanning, only commands change the decode; otherwise HOLD
    // re-asserts the stored index and IDLE keeps everything cleared.
    always_comb begin
        dec_idx_d = addr_q;
        dec_en_d  = (state_q == HOLD);
        if (cmd_accept) begin
            dec_idx_d = cmd_addr;
            dec_en_d  = cmd_enable;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            addr_q  <= '0;
        end else begin
            out_q  <= dec_onehot;
            addr_q <= addr_d;
            if (cmd_accept) begin
                state_q <= cmd_enable ? HOLD : IDLE;
            end
        end
    end

`endif

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder
// Directed self-checking bench for seq_decoder with ADDR_W=2, DWELL=2.
// Covers both builds: with SEQ_DECODER_SCAN_EN the scan sequence is walked,
// without it the scan controls are expected to have no effect.
module tb_seq_decoder;

    localparam int ADDR_W = 2;
    localparam int DWELL  = 2;

    logic        clk;
    logic        rstN;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdAddr;
    logic        cmdEnable;
    logic        scanStart;
    logic        scanStop;
    logic [3:0]  outBus;
    logic [1:0]  addrOut;
    logic        busy;

    int testCount = 0;
    int failCount = 0;

    seq_decoder #(
        .ADDR_W (ADDR_W),
        .DWELL  (DWELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_addr   (cmdAddr),
        .cmd_enable (cmdEnable),
        .scan_start (scanStart),
        .scan_stop  (scanStop),
        .out        (outBus),
        .addr_out   (addrOut),
        .busy       (busy)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every input at once; called 1 unit after a rising edge.
    task automatic applyStimulus(input logic valid, input logic [1:0] addr,
                                 input logic en, input logic start,
                                 input logic stop);
        cmdValid  = valid;
        cmdAddr   = addr;
        cmdEnable = en;
        scanStart = start;
        scanStop  = stop;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected walk for DWELL=2, starting on the first edge after scan_start.
    logic [3:0] walk [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                             4'b0100, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        rstN = 1'b0;
        #12;
        checkOutput("reset_out", 8'(outBus), 8'h00);
        checkOutput("reset_addr", 8'(addrOut), 8'h00);
        checkOutput("reset_busy", 8'(busy), 8'h00);
        checkOutput("reset_ready", 8'(cmdReady), 8'h01);

        // Release reset between edges; the command must land on the very
        // next rising edge.
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("cmd_set_out", 8'(outBus), 8'h04);
        checkOutput("cmd_set_addr", 8'(addrOut), 8'h02);

        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("cmd_clr_out", 8'(outBus), 8'h00);
        checkOutput("cmd_clr_addr", 8'(addrOut), 8'h00);

        applyStimulus(1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("idle_keep", 8'(outBus), 8'h00);

        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("cmd3_out", 8'(outBus), 8'h08);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("hold_keep_out", 8'(outBus), 8'h08);
        checkOutput("hold_keep_addr", 8'(addrOut), 8'h03);

`ifdef SEQ_DECODER_SCAN_EN
        // Walk from HOLD; a command offered during the scan is refused.
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("walk%0d_out", i), 8'(outBus), 8'(walk[i]));
            checkOutput($sformatf("walk%0d_busy", i), 8'(busy), 8'h01);
            checkOutput($sformatf("walk%0d_ready", i), 8'(cmdReady), 8'h00);
            if (i < 8) tick();
        end
        checkOutput("walk_addr", 8'(addrOut), 8'h00);

        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("stop_out", 8'(outBus), 8'h00);
        checkOutput("stop_busy", 8'(busy), 8'h00);
        checkOutput("stop_ready", 8'(cmdReady), 8'h01);

        // scan_start beats a coincident command.
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("start_cmd_ready", 8'(cmdReady), 8'h00);
        tick();
        checkOutput("start_cmd_out", 8'(outBus), 8'h01);
        checkOutput("start_cmd_busy", 8'(busy), 8'h01);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("walk2_a", 8'(outBus), 8'h01);
        tick();
        checkOutput("walk2_b", 8'(outBus), 8'h02);

        // scan_stop beats scan_start while scanning.
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_stop_out", 8'(outBus), 8'h00);
        checkOutput("start_stop_busy", 8'(busy), 8'h00);

        // Asynchronous reset mid-scan while out is 0100.
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("pre_reset_out", 8'(outBus), 8'h04);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_out", 8'(outBus), 8'h00);
        checkOutput("async_rst_addr", 8'(addrOut), 8'h00);
        checkOutput("async_rst_busy", 8'(busy), 8'h00);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_cmd", 8'(outBus), 8'h02);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rescan_a", 8'(outBus), 8'h01);
        tick();
        checkOutput("rescan_b", 8'(outBus), 8'h01);
        tick();
        checkOutput("rescan_c", 8'(outBus), 8'h02);
`else
        // Scan controls have no effect; out stays at 1000.
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("noscan_ready", 8'(cmdReady), 8'h01);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("noscan_out", 8'(outBus), 8'h08);
        checkOutput("noscan_busy", 8'(busy), 8'h00);
        tick();
        checkOutput("noscan_out2", 8'(outBus), 8'h08);

        // A command alongside scan_start is still accepted.
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("noscan_cmd_out", 8'(outBus), 8'h02);
        checkOutput("noscan_cmd_addr", 8'(addrOut), 8'h01);

        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("noscan_stop_out", 8'(outBus), 8'h02);

        // Asynchronous reset between edges.
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_out", 8'(outBus), 8'h00);
        checkOutput("async_rst_addr", 8'(addrOut), 8'h00);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_cmd", 8'(outBus), 8'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
